muldiv_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M extension, filling the F7_MUL path left open in the ALU control decode.
- Sits in EX beside the single-cycle ALU. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request, stalls the pipeline while iterating, then presents the result for one cycle.
- Implements shift-add multiply and restoring divide, XLEN iterations each, with the RISC-V divide corner cases resolved without iterating.

---
 rtl/muldiv_sequencer_pkg.sv | 25 ++
 rtl/muldiv_sequencer_if.sv | 23 ++
 rtl/muldiv_sequencer_step.sv | 30 +++
 rtl/muldiv_sequencer.sv | 154 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M decode constants and sequencer state encoding for muldiv_sequencer.
package muldiv_sequencer_pkg;

  localparam logic [6:0] F7_MUL = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdCalc = 2'd1,
    MdFin  = 2'd2
  } md_state_e;

  function automatic int unsigned md_cnt_w(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the EX stage and the multi-cycle M-extension unit.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, func3, op_a, op_b,
    input  stall, done, result
  );

  modport slave (
    input  start, flush, func3, op_a, op_b,
    output stall, done, result
  );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*XLEN accumulator.
module muldiv_sequencer_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;
  logic [2*XLEN:0] shl;

  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    shl  = {acc, 1'b0};
    diff = shl[2*XLEN:XLEN] - {1'b0, opnd};
    if (is_div) begin
      // Borrow out of the XLEN+1-bit subtract means the divisor did not fit: restore.
      if (diff[XLEN]) acc_nxt = shl[2*XLEN-1:0];
      else            acc_nxt = {diff[XLEN-1:0], shl[XLEN-1:1], 1'b1};
    end else if (acc[0]) begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: FSM, counter, sign fix-up and result register.
// Optional MULDIV_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  localparam int unsigned CntW = md_cnt_w(XLEN);

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   opnd_q, opnd_d, res_q, res_d, fix_res;
  logic              neg_q, neg_d, sp_q, sp_d;

  logic              is_div_in, sgn_a, sgn_b, div0, ovf, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b, sp_val, qr, qr_fix;
  logic              stall, done;
  logic [XLEN-1:0]   result;

  muldiv_sequencer_step #(.XLEN(XLEN)) u_step (
    .is_div  (f3_q[2]),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_step)
  );

  // Request decode: signedness, magnitudes and the divide corner cases.
  always_comb begin
    is_div_in = bus.func3[2];
    sgn_a  = (is_div_in ? ~bus.func3[0] : (bus.func3[1] ^ bus.func3[0])) & bus.op_a[XLEN-1];
    sgn_b  = (is_div_in ? ~bus.func3[0] : (bus.func3[1:0] == 2'b01)) & bus.op_b[XLEN-1];
    mag_a  = sgn_a ? -bus.op_a : bus.op_a;
    mag_b  = sgn_b ? -bus.op_b : bus.op_b;
    neg_in = (is_div_in & bus.func3[1]) ? sgn_a : (sgn_a ^ sgn_b);
    div0   = is_div_in & (bus.op_b == '0);
    ovf    = is_div_in & ~bus.func3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);
    if (div0) sp_val = bus.func3[1] ? bus.op_a : '1;
    else      sp_val = bus.func3[1] ? '0 : bus.op_a;
  end

  // Sign fix-up of the finished accumulator.
  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    qr     = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    qr_fix = neg_q ? -qr : qr;
    if (sp_q)                   fix_res = acc_q[XLEN-1:0];
    else if (f3_q[2])           fix_res = qr_fix;
    else if (f3_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                        fix_res = prod[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] One = XLEN'(1);
  logic [XLEN-1:0] rem_mask;
  logic            early;
  always_comb begin
    rem_mask = (One << cnt_q) - One;
    early    = ~f3_q[2] & ((acc_step[XLEN-1:0] & rem_mask) == '0);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    sp_d    = sp_q;
    res_d   = res_q;
    stall   = 1'b0;
    done    = 1'b0;
    result  = res_q;
    unique case (state_q)
      MdIdle: begin
        if (bus.start && !bus.flush) begin
          stall = 1'b1;
          f3_d  = bus.func3;
          neg_d = neg_in;
          cnt_d = CntW'(XLEN - 1);
          if (div0 || ovf) begin
            sp_d    = 1'b1;
            acc_d   = {{XLEN{1'b0}}, sp_val};
            state_d = MdFin;
          end else begin
            sp_d    = 1'b0;
            acc_d   = {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
            opnd_d  = is_div_in ? mag_b : mag_a;
            state_d = MdCalc;
          end
        end
      end
      MdCalc: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = MdIdle;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = MdFin;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            acc_d   = acc_step >> cnt_q;
            state_d = MdFin;
          end
`endif
        end
      end
      MdFin: begin
        state_d = MdIdle;
        if (!bus.flush) begin
          done   = 1'b1;
          result = fix_res;
          res_d  = fix_res;
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      f3_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      sp_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      sp_q    <= sp_d;
      res_q   <= res_d;
    end
  end

  assign bus.stall  = stall;
  assign bus.done   = done;
  assign bus.result = result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, flush and reset abort cases.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_e;
  string       mon_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #2;
    if (bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h, expected no done", bus.result);
      end else begin
        mon_e = exp_q.pop_front();
        mon_s = name_q.pop_front();
        chk(mon_s, bus.result, mon_e);
      end
    end
  end

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat, input string nm,
                     input bit repulse);
    int lat;
    int stalls;
    @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = f3;
    bus.op_a  = a;
    bus.op_b  = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    #1;
    stalls = bus.stall ? 1 : 0;
    lat    = 0;
    do begin
      @(negedge clk);
      lat++;
      // Operands change after acceptance; stray starts mid-op must be ignored.
      bus.op_a  = ~a;
      bus.start = repulse && (lat == 5 || lat == 6);
      #1;
      if (bus.stall) stalls++;
    end while (bus.done !== 1'b1 && lat < 100);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_stall_cycles"}, stalls, exp_lat);
    bus.start = 1'b0;
  endtask

  int d0;

  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.func3 = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst = 1'b1;

    // flush in IDLE blocks acceptance
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("idle_flush_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("idle_flush_not_accepted", 32'(bus.stall), 32'd0);

    run(F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3", 1'b0);
    run(F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min_min", 1'b0);
    run(F3_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33, "mulhu_2p31", 1'b0);
    run(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_m1", 1'b0);
    run(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max", 1'b0);
    run(F3_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, "mulh_7_m3", 1'b0);
    run(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh_m1_m1", 1'b0);
    run(F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2", 1'b0);
    run(F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2", 1'b0);
    run(F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7_m2", 1'b0);
    run(F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33, "rem_7_m2", 1'b0);
    run(F3_DIVU,   32'd100,      32'd7,        32'd14,       33, "divu_100_7", 1'b1);
    run(F3_REMU,   32'd100,      32'd7,        32'd2,        33, "remu_100_7", 1'b0);
    run(F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by0", 1'b0);
    run(F3_REM,    32'd5,        32'd0,        32'd5,        1,  "rem_by0", 1'b0);
    run(F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0", 1'b0);
    run(F3_REMU,   32'h80000000, 32'd0,        32'h80000000, 1,  "remu_by0", 1'b0);
    run(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf", 1'b0);
    run(F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf", 1'b0);
    run(F3_MUL,    32'd5,        32'd3,        32'd15,       33, "mul_5_3", 1'b0);

    // flush at CALC iteration 10
    @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = F3_MULHU;
    bus.op_a  = 32'hFFFFFFFF;
    bus.op_b  = 32'hFFFFFFFF;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    #1;
    chk("flush_calc_stall", 32'(bus.stall), 32'd1);
    d0 = n_done;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_idle_stall", 32'(bus.stall), 32'd0);
    chk("flush_idle_done", 32'(bus.done), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_no_done", n_done, d0);
    chk("flush_result_kept", bus.result, 32'd15);
    run(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "after_flush_divu", 1'b0);

    // reset mid-CALC
    @(negedge clk);
    bus.start = 1'b1;
    bus.func3 = F3_REMU;
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(bus.stall), 32'd0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    chk("rst_mid_result", bus.result, 32'd0);
    d0 = n_done;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_done", n_done, d0);
    run(F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "after_rst_mul", 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
